// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: receiver FSM states and bit-order codes.
package serial_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Bit-order codes carried on dir; shared with the shift register and transmitter.
   localparam logic DIR_LSB_FIRST = 1'b1;
   localparam logic DIR_MSB_FIRST = 1'b0;

endpackage

// File: rtl/rx_shift_core.sv
// Receive datapath: WIDTH-bit shift register, bit counter and per-frame latched direction.
module rx_shift_core
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en,
   input  logic             restart,
   input  logic             sin,
   input  logic             dir,
   output logic [WIDTH-1:0] word_c,
   output logic             last_c
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] base;
   logic [CNT_W-1:0] cnt;
   logic             dir_q;
   logic             dir_eff;

   // A restart bit takes dir live and starts from an empty word; otherwise extend the held word.
   always_comb begin
      dir_eff = restart ? dir : dir_q;
      base    = restart ? '0 : sreg;
      word_c  = (dir_eff == DIR_LSB_FIRST) ? {sin, base[WIDTH-1:1]}
                                           : {base[WIDTH-2:0], sin};
      last_c  = shift_en && !restart && (cnt == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sreg  <= '0;
         cnt   <= '0;
         dir_q <= DIR_MSB_FIRST;
      end else if (restart) begin
         sreg  <= word_c;
         cnt   <= CNT_W'(1);
         dir_q <= dir;
      end else if (shift_en) begin
         if (last_c) begin
            sreg <= '0;
            cnt  <= '0;
         end else begin
            sreg <= word_c;
            cnt  <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/serial_rx_deser.sv
// Serial-to-parallel receiver: framing FSM, valid/ready output register, error pulses.
module serial_rx_deser
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_en,
   input  logic             sof,
   input  logic             sin,
   input  logic             dir,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);

   state_t           state;
   state_t           state_nxt;
   logic             restart_c;
   logic             shift_c;
   logic             abort_c;
   logic             last_c;
   logic [WIDTH-1:0] word_c;

   rx_shift_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_c),
      .restart  (restart_c),
      .sin      (sin),
      .dir      (dir),
      .word_c   (word_c),
      .last_c   (last_c)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (bit_en && sof) state_nxt = ST_SHIFT;
         ST_SHIFT: if (bit_en && !sof && last_c) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Non-sof bits outside a frame are dropped; an sof inside a frame aborts it.
   always_comb begin
      restart_c = bit_en && sof;
      shift_c   = 1'b0;
      abort_c   = 1'b0;
      if (state == ST_SHIFT) begin
         shift_c = bit_en && !sof;
         abort_c = bit_en && sof;
      end
   end

   assign busy = (state == ST_SHIFT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q         <= '0;
         q_valid   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= abort_c;
         overrun   <= last_c && q_valid && !q_ready;
         if (last_c && (!q_valid || q_ready)) begin
            q       <= word_c;
            q_valid <= 1'b1;
         end else if (q_valid && q_ready) begin
            q_valid <= 1'b0;
         end
      end
   end

endmodule
